// File: rtl/router_pkg.sv
// Shared definitions for the packet router controller: state encodings and
// default parameter values used by the RTL and its benches.
package router_pkg;

    localparam int NUM_CH_DEF   = 3;
    localparam int ADDR_W_DEF   = 2;
    localparam int WAIT_MAX_DEF = 32;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        WAIT_TILL_EMPTY    = 4'd3,
        LOAD_PARITY        = 4'd4,
        CHECK_PARITY_ERROR = 4'd5,
        FIFO_FULL_STATE    = 4'd6,
        LOAD_AFTER_FULL    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_e;

endpackage

// File: rtl/router_fsm_mc_if.sv
// Handshake/status bundle between the packet source, the destination FIFOs
// and the router controller. The controller uses the slave view.
interface router_fsm_mc_if
    import router_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_packet_valid;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_state;
    logic              wait_timeout;
    logic [ADDR_W-1:0] dest_ch;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_state, wait_timeout,
               dest_ch
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_state, wait_timeout,
               dest_ch
    );
endinterface

// File: rtl/router_wait_timer.sv
// Counts cycles spent waiting for the destination FIFO to drain.
// Held at zero while clear is high, saturates at WAIT_MAX; expired is high
// during the WAIT_MAX-th enabled cycle so the FSM can leave on that edge.
module router_wait_timer #(
    parameter int WAIT_MAX = 32
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // a zero WAIT_MAX disables the timeout entirely
    assign expired = (WAIT_MAX > 0) && enable && (cnt_q >= CNT_LAST);
endmodule

// File: rtl/router_fsm_mc.sv
// Packet router controller: routes a header to one of NUM_CH FIFOs, waits
// for an empty destination (with optional timeout), handles FIFO-full
// stalls and discards packets addressed to a non-existent channel.
module router_fsm_mc
    import router_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic            clock,
    input  logic            resetn,
    router_fsm_mc_if.slave  bus
);
    // Status vectors are padded to the full address space so an
    // out-of-range dest_ch (dropped packet) reads 0 instead of X.
    localparam int NSLOT = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] dest_ch_q, dest_ch_d;
    logic              wait_timeout_q, wait_timeout_d;
    logic [NSLOT-1:0]  full_pad, empty_pad, soft_pad;
    logic              full_dst, empty_dst, soft_dst, addr_ok, timer_expired;

    assign full_pad  = NSLOT'(bus.fifo_full);
    assign empty_pad = NSLOT'(bus.fifo_empty);
    assign soft_pad  = NSLOT'(bus.soft_reset);
    assign full_dst  = full_pad[dest_ch_q];
    assign empty_dst = empty_pad[dest_ch_q];
    assign soft_dst  = soft_pad[dest_ch_q];
    assign addr_ok   = {1'b0, bus.data_in} < (ADDR_W + 1)'(NUM_CH);

    router_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (state_q != WAIT_TILL_EMPTY),
        .enable  (state_q == WAIT_TILL_EMPTY),
        .expired (timer_expired)
    );

    // next-state, destination latch and timeout pulse
    always_comb begin
        state_d        = state_q;
        dest_ch_d      = dest_ch_q;
        wait_timeout_d = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    dest_ch_d = bus.data_in;
                    if (!addr_ok)                     state_d = DROP_PACKET;
                    else if (empty_pad[bus.data_in])  state_d = LOAD_FIRST_DATA;
                    else                              state_d = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (full_dst)            state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_dst) begin
                    state_d = LOAD_FIRST_DATA;
                end else if (timer_expired) begin
                    state_d        = DROP_PACKET;
                    wait_timeout_d = 1'b1;
                end
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = full_dst ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!full_dst) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)           state_d = DECODE_ADDRESS;
                else if (bus.low_packet_valid) state_d = LOAD_PARITY;
                else                           state_d = LOAD_DATA;
            end
            DROP_PACKET: begin
                if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // read-timeout soft reset of the active channel aborts any packet
        if ((state_q != DECODE_ADDRESS) && soft_dst) begin
            state_d        = DECODE_ADDRESS;
            wait_timeout_d = 1'b0;
        end
    end

    // state, destination and timeout registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= DECODE_ADDRESS;
            dest_ch_q      <= '0;
            wait_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dest_ch_q      <= dest_ch_d;
            wait_timeout_q <= wait_timeout_d;
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.drop_state    = (state_q == DROP_PACKET);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                            || (state_q == LOAD_AFTER_FULL);
    assign bus.busy          = (state_q == LOAD_FIRST_DATA) || (state_q == WAIT_TILL_EMPTY)
                            || (state_q == LOAD_PARITY) || (state_q == CHECK_PARITY_ERROR)
                            || (state_q == FIFO_FULL_STATE) || (state_q == LOAD_AFTER_FULL);
    assign bus.wait_timeout  = wait_timeout_q;
    assign bus.dest_ch       = dest_ch_q;
endmodule

// File: tb/tb_router_fsm_mc.sv
// Directed bench for the packet router controller at default parameters.
module tb_router_fsm_mc;
    import router_pkg::*;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;

    router_fsm_mc_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

    router_fsm_mc #(.NUM_CH(3), .ADDR_W(2), .WAIT_MAX(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // expected decode vector: detect, lfd, ld, laf, full, wen, rst_int, busy, drop
    function automatic logic [8:0] exp_dec(state_e s);
        logic [8:0] v;
        v    = '0;
        v[8] = (s == DECODE_ADDRESS);
        v[7] = (s == LOAD_FIRST_DATA);
        v[6] = (s == LOAD_DATA);
        v[5] = (s == LOAD_AFTER_FULL);
        v[4] = (s == FIFO_FULL_STATE);
        v[3] = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
        v[2] = (s == CHECK_PARITY_ERROR);
        v[1] = (s == LOAD_FIRST_DATA) || (s == WAIT_TILL_EMPTY) || (s == LOAD_PARITY)
            || (s == CHECK_PARITY_ERROR) || (s == FIFO_FULL_STATE) || (s == LOAD_AFTER_FULL);
        v[0] = (s == DROP_PACKET);
        return v;
    endfunction

    function automatic logic [8:0] obs();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.drop_state};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid        = 1'b0;
        bus.data_in          = 2'd0;
        bus.fifo_full        = 3'b000;
        bus.fifo_empty       = 3'b111;
        bus.soft_reset       = 3'b000;
        bus.parity_done      = 1'b0;
        bus.low_packet_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #3;
        checks++;
        if (obs() !== exp_dec(DECODE_ADDRESS)) begin
            failures++;
            $display("FAIL reset_decode: got %b expected %b", obs(), exp_dec(DECODE_ADDRESS));
        end
        checks++;
        if (bus.dest_ch !== 2'd0 || bus.wait_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got dest_ch=%0d wait_timeout=%b expected 0/0",
                     bus.dest_ch, bus.wait_timeout);
        end
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (obs() !== exp_dec(DECODE_ADDRESS)) begin
            failures++;
            $display("FAIL reset_idle: got %b expected %b", obs(), exp_dec(DECODE_ADDRESS));
        end
    endtask

    task automatic test_normal();
        state_e seq [8] = '{LOAD_FIRST_DATA, LOAD_DATA, LOAD_DATA, LOAD_DATA, LOAD_DATA,
                            LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS};
        int wen = 0;
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) bus.pkt_valid = 1'b0;
            step();
            if (bus.write_enb_reg === 1'b1) wen++;
            checks++;
            if (obs() !== exp_dec(seq[i])) begin
                failures++;
                $display("FAIL normal_seq[%0d]: got %b expected %b", i, obs(), exp_dec(seq[i]));
            end
        end
        checks++;
        if (wen != 5) begin
            failures++;
            $display("FAIL normal_wen_cycles: got %0d expected 5", wen);
        end
        checks++;
        if (bus.dest_ch !== 2'd1) begin
            failures++;
            $display("FAIL normal_dest_ch: got %0d expected 1", bus.dest_ch);
        end
    endtask

    task automatic test_wait();
        state_e seq [10] = '{WAIT_TILL_EMPTY, WAIT_TILL_EMPTY, WAIT_TILL_EMPTY, WAIT_TILL_EMPTY,
                             WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY,
                             CHECK_PARITY_ERROR, DECODE_ADDRESS};
        idle_inputs();
        bus.fifo_empty = 3'b010;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) bus.pkt_valid = 1'b0;
            if (i == 5) bus.fifo_empty = 3'b110;
            step();
            checks++;
            if (obs() !== exp_dec(seq[i])) begin
                failures++;
                $display("FAIL wait_seq[%0d]: got %b expected %b", i, obs(), exp_dec(seq[i]));
            end
        end
        checks++;
        if (bus.dest_ch !== 2'd2) begin
            failures++;
            $display("FAIL wait_dest_ch: got %0d expected 2", bus.dest_ch);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int pulses = 0;
        idle_inputs();
        bus.fifo_empty = 3'b000;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'd0;
        step();
        while (obs() === exp_dec(WAIT_TILL_EMPTY) && n < 40) begin
            n++;
            if (bus.wait_timeout !== 1'b0) pulses++;
            step();
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL timeout_wait_cycles: got %0d expected 32", n);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL timeout_early_pulse: got %0d pulses in wait expected 0", pulses);
        end
        checks++;
        if (obs() !== exp_dec(DROP_PACKET) || bus.wait_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_drop_entry: got %b wt=%b expected %b wt=1",
                     obs(), bus.wait_timeout, exp_dec(DROP_PACKET));
        end
        step();
        checks++;
        if (obs() !== exp_dec(DROP_PACKET) || bus.wait_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_drop_hold: got %b wt=%b expected %b wt=0",
                     obs(), bus.wait_timeout, exp_dec(DROP_PACKET));
        end
        bus.pkt_valid = 1'b0;
        step();
        checks++;
        if (obs() !== exp_dec(DECODE_ADDRESS)) begin
            failures++;
            $display("FAIL timeout_return: got %b expected %b", obs(), exp_dec(DECODE_ADDRESS));
        end
    endtask

    task automatic test_bad_addr();
        state_e seq [4] = '{DROP_PACKET, DROP_PACKET, DROP_PACKET, DECODE_ADDRESS};
        int wen = 0;
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.pkt_valid = 1'b0;
            step();
            if (bus.write_enb_reg === 1'b1) wen++;
            checks++;
            if (obs() !== exp_dec(seq[i])) begin
                failures++;
                $display("FAIL badaddr_seq[%0d]: got %b expected %b", i, obs(), exp_dec(seq[i]));
            end
            if (i == 0) begin
                checks++;
                if (bus.wait_timeout !== 1'b0 || bus.dest_ch !== 2'd3) begin
                    failures++;
                    $display("FAIL badaddr_entry: got wt=%b dest_ch=%0d expected wt=0 dest_ch=3",
                             bus.wait_timeout, bus.dest_ch);
                end
            end
        end
        checks++;
        if (wen != 0) begin
            failures++;
            $display("FAIL badaddr_writes: got %0d expected 0", wen);
        end
    endtask

    task automatic test_full();
        state_e seq [9] = '{LOAD_FIRST_DATA, LOAD_DATA, LOAD_DATA, FIFO_FULL_STATE,
                            FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY,
                            CHECK_PARITY_ERROR, DECODE_ADDRESS};
        state_e seq2 [5] = '{LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, DECODE_ADDRESS,
                             DECODE_ADDRESS};
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                bus.fifo_full = 3'b010;
                bus.pkt_valid = 1'b0;
            end
            if (i == 4) bus.soft_reset = 3'b001;
            if (i == 5) begin
                bus.fifo_full        = 3'b000;
                bus.soft_reset       = 3'b000;
                bus.low_packet_valid = 1'b1;
            end
            if (i == 7) bus.low_packet_valid = 1'b0;
            step();
            checks++;
            if (obs() !== exp_dec(seq[i])) begin
                failures++;
                $display("FAIL full_seq[%0d]: got %b expected %b", i, obs(), exp_dec(seq[i]));
            end
        end
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.fifo_full = 3'b010;
                bus.pkt_valid = 1'b0;
            end
            if (i == 3) bus.soft_reset = 3'b010;
            if (i == 4) begin
                bus.soft_reset = 3'b000;
                bus.fifo_full  = 3'b000;
            end
            step();
            checks++;
            if (obs() !== exp_dec(seq2[i])) begin
                failures++;
                $display("FAIL softrst_seq[%0d]: got %b expected %b", i, obs(), exp_dec(seq2[i]));
            end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        step();
        step();
        checks++;
        if (obs() !== exp_dec(LOAD_DATA) || bus.dest_ch !== 2'd2) begin
            failures++;
            $display("FAIL areset_pre: got %b dest_ch=%0d expected %b dest_ch=2",
                     obs(), bus.dest_ch, exp_dec(LOAD_DATA));
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (obs() !== exp_dec(DECODE_ADDRESS) || bus.dest_ch !== 2'd0) begin
            failures++;
            $display("FAIL areset_immediate: got %b dest_ch=%0d expected %b dest_ch=0",
                     obs(), bus.dest_ch, exp_dec(DECODE_ADDRESS));
        end
        bus.data_in = 2'd1;
        #1;
        resetn = 1'b1;
        step();
        checks++;
        if (obs() !== exp_dec(LOAD_FIRST_DATA) || bus.dest_ch !== 2'd1) begin
            failures++;
            $display("FAIL areset_first_edge: got %b dest_ch=%0d expected %b dest_ch=1",
                     obs(), bus.dest_ch, exp_dec(LOAD_FIRST_DATA));
        end
        bus.pkt_valid = 1'b0;
        step();
        step();
        step();
        step();
        checks++;
        if (obs() !== exp_dec(DECODE_ADDRESS)) begin
            failures++;
            $display("FAIL areset_drain: got %b expected %b", obs(), exp_dec(DECODE_ADDRESS));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_normal();
        test_wait();
        test_timeout();
        test_bad_addr();
        test_full();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_fsm_mc.md
ROUTER_FSM_MC -- requirements
Module: router_fsm_mc

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 3, number of destination FIFOs (2..16); ADDR_W, default 2, address field width, 2**ADDR_W >= NUM_CH; WAIT_MAX, default 32, WAIT_TILL_EMPTY timeout in cycles, 0 = timeout disabled.
REQ-002 Ports SHALL be (name direction width meaning):
- clock in 1: sole clock, rising edge.
- resetn in 1: asynchronous active-low reset.
- pkt_valid in 1: header/payload valid from source.
- data_in in ADDR_W: destination address field of the header byte.
- fifo_full in NUM_CH: per-FIFO full.
- fifo_empty in NUM_CH: per-FIFO empty.
- soft_reset in NUM_CH: per-FIFO read-timeout soft reset.
- parity_done in 1: parity byte loaded.
- low_packet_valid in 1: pkt_valid fell while FIFO full.
- detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy out 1 each: state decodes.
- drop_state out 1: packet being discarded.
- wait_timeout out 1: one-cycle timeout pulse.
- dest_ch out ADDR_W: latched destination of the current packet.

Function
REQ-003 The FSM SHALL have 9 states in a 4-bit encoding: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE, LOAD_AFTER_FULL, DROP_PACKET.
REQ-004 In DECODE_ADDRESS with pkt_valid=1, dest_ch SHALL load data_in on the same edge as the transition; dest_ch SHALL hold in every other state.
REQ-005 DECODE_ADDRESS SHALL go to DROP_PACKET if pkt_valid and data_in>=NUM_CH; else to LOAD_FIRST_DATA if pkt_valid and fifo_empty[data_in]; else to WAIT_TILL_EMPTY if pkt_valid; else it SHALL stay.
REQ-006 LOAD_FIRST_DATA SHALL go to LOAD_DATA unconditionally.
REQ-007 LOAD_DATA SHALL go to FIFO_FULL_STATE if fifo_full[dest_ch]; else to LOAD_PARITY if !pkt_valid; else it SHALL stay. Full takes priority over a simultaneous pkt_valid fall.
REQ-008 WAIT_TILL_EMPTY SHALL examine only fifo_empty[dest_ch]. It SHALL go to LOAD_FIRST_DATA when that bit is 1. Otherwise, with WAIT_MAX>0, it SHALL go to DROP_PACKET once WAIT_MAX cycles have been spent in the state; else it SHALL stay. Empty wins over an expiring timer in the same cycle.
REQ-009 The wait counter SHALL clear on entry to WAIT_TILL_EMPTY and saturate; wait_timeout SHALL be 1 for exactly the first DROP_PACKET cycle entered via timeout.
REQ-010 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR; CHECK_PARITY_ERROR SHALL go to FIFO_FULL_STATE if fifo_full[dest_ch], else to DECODE_ADDRESS.
REQ-011 FIFO_FULL_STATE SHALL stay while fifo_full[dest_ch], else go to LOAD_AFTER_FULL.
REQ-012 LOAD_AFTER_FULL SHALL go to DECODE_ADDRESS if parity_done; else to LOAD_PARITY if low_packet_valid; else to LOAD_DATA.
REQ-013 DROP_PACKET SHALL stay while pkt_valid=1, then go to DECODE_ADDRESS. No write is issued and busy=0 throughout.
REQ-014 soft_reset[dest_ch]=1 in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS on the next edge, overriding every transition. soft_reset bits of other channels SHALL be ignored.
REQ-015 Outputs SHALL be Moore decodes of the present state:
- detect_add = DECODE_ADDRESS.
- lfd_state = LOAD_FIRST_DATA.
- ld_state = LOAD_DATA.
- laf_state = LOAD_AFTER_FULL.
- full_state = FIFO_FULL_STATE.
- rst_int_reg = CHECK_PARITY_ERROR.
- drop_state = DROP_PACKET.
- write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
- busy = LOAD_FIRST_DATA | WAIT_TILL_EMPTY | LOAD_PARITY | CHECK_PARITY_ERROR | FIFO_FULL_STATE | LOAD_AFTER_FULL.
REQ-016 Undefined state codes SHALL recover to DECODE_ADDRESS on the next edge.

Reset
REQ-017 resetn=0 SHALL asynchronously set the state to DECODE_ADDRESS, dest_ch=0, wait counter=0, and wait_timeout=0. All outputs SHALL be 0 except detect_add=1.
REQ-018 Reset deassertion SHALL be sampled synchronously; the first transition occurs on the first edge with resetn=1.

Structure
REQ-019 State encodings and default parameter values SHALL reside in shared package router_pkg, for reuse by the router top and benches.
REQ-020 The wait counter SHALL be sub-module router_wait_timer (inputs clear/enable, output expired). All other logic is single-module.

Verification
REQ-021 Bench SHALL cover, default parameters:
- Addr 1, fifo_empty=3'b111, 4-byte payload: DECODE→LFD→LD×4→LP→CPE→DECODE; write_enb_reg high 5 cycles; dest_ch=1.
- Addr 2, fifo_empty[2]=0 for 5 cycles, fifo_empty[0]=0 throughout: WAIT for 5 cycles, then LFD; channel 0 has no effect.
- Addr 0, FIFO never empties: DROP entered after exactly 32 WAIT cycles; wait_timeout one-cycle pulse; busy=0 until pkt_valid falls.
- Header addr 3: direct DROP, zero writes, return to DECODE the cycle after pkt_valid=0.
- fifo_full[1] mid-payload, low_packet_valid=1 on release: LD→FULL→LAF→LP→CPE; soft_reset[1] in FULL → DECODE next edge; soft_reset[0] ignored.
- resetn pulsed low between edges in LOAD_DATA: detect_add=1 and dest_ch=0 immediately, before the next clock edge.
